// File: rtl/core_pkg.sv
// Shared core definitions: default register-file geometry
// and RISC-V ABI register indices.
package core_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;

   typedef enum logic [4:0] {
      ZERO = 5'd0,
      RA   = 5'd1,
      SP   = 5'd2,
      GP   = 5'd3,
      TP   = 5'd4,
      T0   = 5'd5,
      T1   = 5'd6,
      T2   = 5'd7,
      S0   = 5'd8,
      S1   = 5'd9,
      A0   = 5'd10,
      A1   = 5'd11
   } abi_reg_e;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback side bundle of the register file:
// two read ports, one write port, scoreboard set, busy flags.
interface reg_file_sb_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic [AW-1:0]   a1;
   logic [XLEN-1:0] rd1;
   logic            busy1;
   logic [AW-1:0]   a2;
   logic [XLEN-1:0] rd2;
   logic            busy2;
   logic            we3;
   logic [AW-1:0]   a3;
   logic [XLEN-1:0] wd3;
   logic            sb_set;
   logic [AW-1:0]   sb_addr;
   logic            any_busy;

   modport master (
      output a1, a2, we3, a3, wd3, sb_set, sb_addr,
      input  rd1, rd2, busy1, busy2, any_busy
   );

   modport slave (
      input  a1, a2, we3, a3, wd3, sb_set, sb_addr,
      output rd1, rd2, busy1, busy2, any_busy
   );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register pending bits: writeback clears, issue sets,
// and a set on the same register wins over the clear.
module reg_scoreboard #(
   parameter int NREG     = 32,
   parameter int ZERO_REG = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    set_i,
   input  logic [$clog2(NREG)-1:0] set_addr_i,
   input  logic                    clr_i,
   input  logic [$clog2(NREG)-1:0] clr_addr_i,
   output logic [NREG-1:0]         pend_o,
   output logic                    any_busy_o
);

   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] pend_d;
   logic            set_ok;

   assign set_ok = set_i
                 && !((ZERO_REG != 0) && (set_addr_i == '0));

   // Next pend vector: clear first so a new producer's set overrides it
   always_comb begin
      pend_d = pend_q;
      if (clr_i) begin
         pend_d[clr_addr_i] = 1'b0;
      end
      if (set_ok) begin
         pend_d[set_addr_i] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         pend_d[0] = 1'b0;
      end
   end

   // Pend state, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pend_o     = pend_q;
   assign any_busy_o = |pend_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised 2R1W register file with optional write bypass,
// hardwired zero register and a pending-producer scoreboard.
module reg_file_sb
   import core_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREG     = NREG_DEF,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input logic          clk,
   input logic          rst_n,
   reg_file_sb_if.slave rf
);

   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] regs_q [NREG];
   logic [NREG-1:0] pend;
   logic            any_busy;
   logic            wr_en;
   logic            z1;
   logic            z2;
   logic            byp1;
   logic            byp2;

   assign wr_en = rf.we3
                && !((ZERO_REG != 0) && (rf.a3 == '0));

   assign z1 = (ZERO_REG != 0) && (rf.a1 == '0);
   assign z2 = (ZERO_REG != 0) && (rf.a2 == '0);

   assign byp1 = (BYPASS != 0) && rf.we3
               && (rf.a1 == rf.a3) && !z1;
   assign byp2 = (BYPASS != 0) && rf.we3
               && (rf.a2 == rf.a3) && !z2;

   // Register array: async clear, one-cycle write latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[rf.a3] <= rf.wd3;
      end
   end

   reg_scoreboard #(
      .NREG     (NREG),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_i      (rf.sb_set),
      .set_addr_i (rf.sb_addr),
      .clr_i      (rf.we3),
      .clr_addr_i (rf.a3),
      .pend_o     (pend),
      .any_busy_o (any_busy)
   );

   // Read port 1: zero reg, forwarded write, or stored value;
   // the bypass is masked during reset so outputs stay quiet
   always_comb begin
      rf.rd1   = '0;
      rf.busy1 = 1'b0;
      if (rst_n && !z1) begin
         if (byp1) begin
            rf.rd1 = rf.wd3;
         end else begin
            rf.rd1   = regs_q[rf.a1];
            rf.busy1 = pend[rf.a1];
         end
      end
   end

   // Read port 2: same selection as port 1
   always_comb begin
      rf.rd2   = '0;
      rf.busy2 = 1'b0;
      if (rst_n && !z2) begin
         if (byp2) begin
            rf.rd2 = rf.wd3;
         end else begin
            rf.rd2   = regs_q[rf.a2];
            rf.busy2 = pend[rf.a2];
         end
      end
   end

   assign rf.any_busy = rst_n && any_busy;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 32x32 three-port register file: configurable data width and register count, optional write-to-read bypass, and asynchronous clear of all registers.
- Adds a per-register pending scoreboard. The issue stage marks a destination as busy when a multi-cycle producer (load, divide) issues; the writeback clears it.
- Sits between decode (read ports a1/a2, busy flags) and writeback (write port a3); drives the stall logic of the pipelined core.

Parameters:
- XLEN, 32, data width in bits of every register.
- NREG, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREG), register address width; derived, not to be overridden.
- BYPASS, 1, 1 = a read of the register being written this cycle returns wd3; 0 = it returns the old value.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never pending; 0 = register 0 is an ordinary register.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a1  in  AW  read port 1 address
- rd1  out  XLEN  read port 1 data
- busy1  out  1  register a1 is pending
- a2  in  AW  read port 2 address
- rd2  out  XLEN  read port 2 data
- busy2  out  1  register a2 is pending
- we3  in  1  write enable
- a3  in  AW  write address
- wd3  in  XLEN  write data
- sb_set  in  1  mark register sb_addr pending
- sb_addr  in  AW  scoreboard set address
- any_busy  out  1  OR of all pending bits, used for drain and fence

Behaviour:
- Reset: the asynchronous assertion of rst_n=0 clears every register to 0 and every pending bit to 0, in any cycle including mid-write.
  - While rst_n=0, rd1 and rd2 show 0 and busy1, busy2 and any_busy are 0.
  - Writes and sb_set are ignored until the first rising edge after deassertion.
- Write: on the rising edge, when we3=1 (and a3!=0 if ZERO_REG=1), regs[a3] <= wd3. One-cycle write latency.
- Read: combinational from a1 and a2; zero latency.
  - ZERO_REG=1 and the address is 0: data 0, busy 0.
  - BYPASS=1, we3=1 and the address equals a3 (non-zero): data is wd3, busy is 0 (the value is being forwarded).
  - Otherwise: data is regs[addr], busy is pend[addr].
- Scoreboard, evaluated at each rising edge:
  - we3=1 with a3=r clears pend[r].
  - sb_set=1 with sb_addr=r sets pend[r].
  - Both on the same r in the same cycle: set wins, because a new producer has issued behind the completing one; pend[r]=1 afterwards.
  - sb_set to register 0 with ZERO_REG=1 is ignored.
  - sb_set to an already pending register leaves it pending; no counting and no error.
  - A write to a non-pending register is a normal write; pend is unchanged.
- any_busy is combinational from the pend vector; it does not reflect this cycle's set or clear until the next edge.
- Out-of-range addresses cannot occur, because NREG is a power of two.
- No other state. No X may reach the outputs after reset.

Decomposition:
- Shared package (core_pkg): XLEN default, NREG default, ABI register index constants (ZERO, RA, SP, ...).
- One sub-module, reg_scoreboard: holds the NREG-bit pend vector with set/clear priority and any_busy. Parameters NREG and ZERO_REG.
- The register array, the bypass muxes and the busy muxing stay in reg_file_sb.

Test Plan:
- Reset then write 55 to x1 and 99 to x2; read a1=1, a2=2 -> rd1=55, rd2=99, busy1=busy2=0.
- we3=1, a3=0, wd3=777 with ZERO_REG=1; read a1=0 -> rd1=0 both in the write cycle and in the following cycle.
- BYPASS=1: x5 holds 10; in one cycle we3=1, a3=5, wd3=20 with a1=5 -> rd1=20 in that cycle. Repeat with BYPASS=0 -> rd1=10 in that cycle, 20 in the next.
- sb_set with sb_addr=7 -> next cycle busy1=1 for a1=7 and any_busy=1.
  - Write 42 to x7 -> busy1=0 in the write cycle (bypass) and rd1=42.
  - any_busy=0 from the next cycle.
- x3 pending; in one cycle sb_set, sb_addr=3 and we3=1, a3=3, wd3=8 -> next cycle rd for x3=8 and busy=1 (set wins).
- XLEN=16, NREG=8: write 0xBEEF to x7, then assert rst_n=0 mid-cycle with sb_set pending -> immediately rd1=0 and any_busy=0; after release x7 reads 0.
